sram_bus_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SRAM-like (req/addr_ok/data_ok) protocol. It shares a single memory port between the instruction-fetch master (the IF stage) and the data master (the MEM stage). Address-phase requests are granted by fixed priority, data over instruction, and held until accepted. An in-order ID FIFO routes each `data_ok` back to the master that issued the request. The block sits between the CPU core and the AXI bridge inside the CPU top.

---
 rtl/sram_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like req/addr_ok/data_ok bus.
// Optional inst starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_bus_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err_unexpected
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } lock_t;

    lock_t          gnt_lock_q;
    lock_t          gnt_lock_d;
    logic           fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [PW:0]    count_q;
    logic           err_q;

    logic           starve_hit;
    logic           pick_data;
    logic           gnt_id;
    logic           gnt_req;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           head_id;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0]  starve_cnt_q;

    assign starve_hit = (starve_cnt_q >= SW'(STARVE_LIMIT));

    // Counts data acceptances that happened while inst was kept waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (push && !gnt_id) begin
            starve_cnt_q <= '0;
        end else if (push && gnt_id && inst_req && !starve_hit) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign starve_hit          = 1'b0;
`endif

    assign pick_data  = data_req && !(starve_hit && inst_req);
    assign fifo_full  = (count_q == (PW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);

    always_comb begin
        gnt_id = pick_data;
        case (gnt_lock_q)
            LOCK_I:  gnt_id = 1'b0;
            LOCK_D:  gnt_id = 1'b1;
            default: gnt_id = pick_data;
        endcase
    end

    assign gnt_req = gnt_id ? data_req : inst_req;
    assign mem_req = gnt_req && !fifo_full;
    assign push    = mem_req && mem_addr_ok;
    assign pop     = mem_data_ok && !fifo_empty;
    assign head_id = fifo_mem[rd_ptr_q];

    // Hold the grant while the slave stalls; a full FIFO neither locks nor unlocks.
    always_comb begin
        gnt_lock_d = gnt_lock_q;
        if (mem_req && !mem_addr_ok) begin
            gnt_lock_d = gnt_id ? LOCK_D : LOCK_I;
        end else if (push || !gnt_req) begin
            gnt_lock_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_lock_q <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            gnt_lock_q <= gnt_lock_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (mem_data_ok && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= gnt_id;
        end
    end

    assign mem_wr         = gnt_id ? data_wr    : 1'b0;
    assign mem_size       = gnt_id ? data_size  : 2'd2;
    assign mem_wstrb      = gnt_id ? data_wstrb : 4'd0;
    assign mem_addr       = gnt_id ? data_addr  : inst_addr;
    assign mem_wdata      = gnt_id ? data_wdata : 32'd0;

    assign inst_addr_ok   = push && !gnt_id;
    assign data_addr_ok   = push && gnt_id;
    assign inst_data_ok   = pop && !head_id;
    assign data_data_ok   = pop && head_id;
    assign inst_rdata     = mem_rdata;
    assign data_rdata     = mem_rdata;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Vector-table and scoreboard bench for sram_bus_arbiter (DEPTH=4, STARVE_LIMIT=4).
// Starvation expectations follow SRAM_ARB_STARVE_GUARD_EN.
module tb_sram_bus_arbiter;

    localparam logic [1:0]  DSIZE  = 2'd0;
    localparam logic [3:0]  DSTRB  = 4'b0001;
    localparam logic [31:0] DWDATA = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err_unexpected;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_unexpected(err_unexpected)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic        maok;
        logic        mdok;
        logic [31:0] rdata;
        logic        e_mreq;
        logic        e_gd;
        logic        e_iaok;
        logic        e_daok;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   exp_q[$];
    logic err_exp;
    vec_t tbl[15];

    function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwr, input logic [31:0] daddr,
                                input logic maok, input logic mdok, input logic [31:0] rdata,
                                input logic e_mreq, input logic e_gd,
                                input logic e_iaok, input logic e_daok);
        vec_t v;
        v.ireq = ireq;   v.iaddr = iaddr; v.dreq = dreq;     v.dwr = dwr;
        v.daddr = daddr; v.maok = maok;   v.mdok = mdok;     v.rdata = rdata;
        v.e_mreq = e_mreq; v.e_gd = e_gd; v.e_iaok = e_iaok; v.e_daok = e_daok;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inst_req    = v.ireq;
        inst_addr   = v.iaddr;
        data_req    = v.dreq;
        data_wr     = v.dwr;
        data_addr   = v.daddr;
        mem_addr_ok = v.maok;
        mem_data_ok = v.mdok;
        mem_rdata   = v.rdata;
    endtask

    // One bus cycle: drive, check at negedge, update scoreboard, advance past posedge.
    task automatic apply(input string tag, input vec_t v);
        bit id;
        drive(v);
        @(negedge clk);
        chk(tag, "mem_req", 32'(mem_req), 32'(v.e_mreq));
        chk(tag, "inst_addr_ok", 32'(inst_addr_ok), 32'(v.e_iaok));
        chk(tag, "data_addr_ok", 32'(data_addr_ok), 32'(v.e_daok));
        chk(tag, "err_unexpected", 32'(err_unexpected), 32'(err_exp));
        if (v.e_mreq) begin
            chk(tag, "mem_addr", mem_addr, v.e_gd ? v.daddr : v.iaddr);
            chk(tag, "mem_wr", 32'(mem_wr), 32'(v.e_gd ? v.dwr : 1'b0));
            chk(tag, "mem_size", 32'(mem_size), 32'(v.e_gd ? DSIZE : 2'd2));
            chk(tag, "mem_wstrb", 32'(mem_wstrb), 32'(v.e_gd ? DSTRB : 4'd0));
            chk(tag, "mem_wdata", mem_wdata, v.e_gd ? DWDATA : 32'd0);
        end
        if (v.mdok && exp_q.size() > 0) begin
            id = exp_q.pop_front();
            chk(tag, "inst_data_ok", 32'(inst_data_ok), 32'(!id));
            chk(tag, "data_data_ok", 32'(data_data_ok), 32'(id));
            chk(tag, "rdata", id ? data_rdata : inst_rdata, v.rdata);
        end else begin
            chk(tag, "data_ok_pair", 32'({inst_data_ok, data_data_ok}), 32'd0);
            if (v.mdok) err_exp = 1'b1;
        end
        if (v.e_iaok) exp_q.push_back(1'b0);
        if (v.e_daok) exp_q.push_back(1'b1);
        $display("%s: req i/d=%b/%b mem_req=%b addr=%h aok i/d=%b/%b dok i/d=%b/%b err=%b",
                 tag, inst_req, data_req, mem_req, mem_addr, inst_addr_ok, data_addr_ok,
                 inst_data_ok, data_data_ok, err_unexpected);
        @(posedge clk);
        #1;
    endtask

    task automatic sync_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        err_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gd;
        data_size  = DSIZE;
        data_wstrb = DSTRB;
        data_wdata = DWDATA;
        err_exp    = 1'b0;
        reset      = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //          ireq iaddr          dreq wr daddr          aok dok rdata         mreq gd iaok daok
        tbl[0]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h1C00_0000, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 1, 0);
        tbl[2]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0);
        tbl[3]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h0280_0000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 32'h1C00_0004, 1, 0, 32'h8000_0010, 1, 0, 32'h0,         1, 1, 0, 1);
        tbl[5]  = mk(1, 32'h1C00_0004, 0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 1, 0);
        tbl[6]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h1111_1111, 0, 0, 0, 0);
        tbl[7]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h2222_2222, 0, 0, 0, 0);
        tbl[8]  = mk(1, 32'h1C00_0008, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0);
        tbl[9]  = mk(1, 32'h1C00_0008, 1, 1, 32'h8000_0020, 0, 0, 32'h0,         1, 0, 0, 0);
        tbl[10] = mk(1, 32'h1C00_0008, 1, 1, 32'h8000_0020, 0, 0, 32'h0,         1, 0, 0, 0);
        tbl[11] = mk(1, 32'h1C00_0008, 1, 1, 32'h8000_0020, 1, 0, 32'h0,         1, 0, 1, 0);
        tbl[12] = mk(0, 32'h0,         1, 1, 32'h8000_0020, 1, 0, 32'h0,         1, 1, 0, 1);
        tbl[13] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h3333_3333, 0, 0, 0, 0);
        tbl[14] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h4444_4444, 0, 0, 0, 0);

        #2;
        chk("reset", "err_unexpected", 32'(err_unexpected), 32'd0);
        chk("reset", "mem_req", 32'(mem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Fill to DEPTH, then full blocks requests; a pop frees a slot only the cycle after.
        for (int k = 0; k < 4; k++) begin
            apply($sformatf("fill%0d", k), mk(1, 32'h1C00_0100 + 32'(4*k), 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        end
        apply("full_block", mk(1, 32'h1C00_0110, 1, 0, 32'h8000_0100, 1, 0, 0, 0, 0, 0, 0));
        apply("full_pop",   mk(1, 32'h1C00_0110, 0, 0, 0, 1, 1, 32'h5555_5555, 0, 0, 0, 0));
        apply("full_reopen", mk(1, 32'h1C00_0110, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            apply($sformatf("drain%0d", k), mk(0, 0, 0, 0, 0, 0, 1, 32'h6000_0000 + 32'(k), 0, 0, 0, 0));
        end

        // Unexpected response, sticky error, then asynchronous reset mid-cycle.
        apply("err_set",    mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0));
        apply("err_sticky", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        apply("pre_acc",    mk(1, 32'h1C00_0200, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
        apply("pre_lock",   mk(1, 32'h1C00_0204, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", "err_unexpected", 32'(err_unexpected), 32'd0);
        chk("async_rst", "mem_req", 32'(mem_req), 32'd1);
        inst_req = 1'b0;
        #2;
        reset = 1'b0;
        exp_q.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #1;
        apply("post_rst_arb", mk(1, 32'h1C00_0204, 1, 0, 32'h8000_0200, 1, 0, 0, 1, 1, 0, 1));
        apply("post_rst_rsp", mk(0, 0, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 0, 0, 0));
        apply("post_rst_err", mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0));
        apply("post_rst_chk", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));

        // Both masters requesting continuously, one response per cycle after the first.
        sync_reset();
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
            gd = !(i == 4 || i == 9);
`else
            gd = 1'b1;
`endif
            apply($sformatf("starve%0d", i),
                  mk(1, 32'h1C00_0400 + 32'(4*i), 1, 0, 32'h8000_0400 + 32'(4*i), 1, (i > 0),
                     32'h9000_0000 + 32'(i), 1, gd, !gd, gd));
        end
        apply("starve_drain", mk(0, 0, 0, 0, 0, 0, 1, 32'h9000_00FF, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
